// File: rtl/boot_pkg.sv
// Shared definitions for the UART boot loader: FSM encoding and framing constants.
package boot_pkg;

    typedef enum logic [1:0] {
        S_LEN  = 2'd0,
        S_DATA = 2'd1,
        S_RUN  = 2'd2,
        S_ERR  = 2'd3
    } boot_state_e;

    localparam int LANES = 4;
    localparam int LEN_W = 32;

endpackage

// File: rtl/uart_boot_loader_if.sv
// Instruction-memory write port driven by the boot loader.
// Handshake: imem_we qualifies imem_addr/imem_wdata for exactly one cycle; the memory
// has no ready, so every cycle with imem_we=1 is one accepted word write.
interface uart_boot_loader_if #(
    parameter int ADDR_W = 14
);
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (output imem_we, imem_addr, imem_wdata);
    modport slave  (input  imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/byte_assembler.sv
// Packs a byte stream into little-endian 32-bit words; word_done marks the 4th byte,
// and word is valid only in that cycle (the top byte is taken straight from byte_in).
module byte_assembler
    import boot_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             byte_valid,
    input  logic [7:0]       byte_in,
    output logic [LEN_W-1:0] word,
    output logic             word_done
);
    logic [1:0]  lane_q;
    logic [23:0] data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_q <= 2'd0;
            data_q <= 24'd0;
        end else if (byte_valid) begin
            case (lane_q)
                2'd0:    data_q[7:0]   <= byte_in;
                2'd1:    data_q[15:8]  <= byte_in;
                2'd2:    data_q[23:16] <= byte_in;
                default: ;
            endcase
            lane_q <= lane_q + 2'd1;
        end
    end

    assign word_done = byte_valid && (lane_q == 2'(LANES - 1));
    assign word      = {byte_in, data_q};
endmodule

// File: rtl/uart_boot_loader.sv
// Boot sequencer: reads a length-prefixed image from the UART RX FIFO into instruction
// memory, then releases the core and hands the FIFO read port over to it.
module uart_boot_loader
    import boot_pkg::*;
#(
    parameter int ADDR_W    = 14,
    parameter int BASE      = 0,
    parameter int MAX_WORDS = 2**ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 uart_empty,
    input  logic [7:0]           uart_in,
    output logic                 uart_rdreq,
    input  logic                 core_uart_rdreq,
    output logic                 core_uart_empty,
    uart_boot_loader_if.master   imem,
    output logic                 core_run,
    output logic                 boot_err,
    output boot_state_e          dbg_state
);
    localparam logic [ADDR_W:0] IDX_ONE = 1;

    boot_state_e       state_q, state_d;
    logic              rd_pending_q;
    logic              fetch_done_q;
    logic              last_wr_q;
    logic              fetch_en;
    logic [ADDR_W:0]   idx_q;
    logic [ADDR_W:0]   len_q;
    logic [LEN_W-1:0]  word;
    logic              word_done;

    // uart_in is valid the cycle after the request, so the pending flag doubles as byte_valid.
    byte_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (rd_pending_q),
        .byte_in    (uart_in),
        .word       (word),
        .word_done  (word_done)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_LEN;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d         = state_q;
        uart_rdreq      = 1'b0;
        core_uart_empty = 1'b1;
        core_run        = 1'b0;
        boot_err        = 1'b0;
        fetch_en        = 1'b0;
        case (state_q)
            S_LEN: begin
                fetch_en = 1'b1;
                if (word_done) begin
                    if (word > LEN_W'(MAX_WORDS)) state_d = S_ERR;
                    else if (word == '0)          state_d = S_RUN;
                    else                          state_d = S_DATA;
                end
            end
            S_DATA: begin
                // Stop fetching once the last word is assembled; later bytes belong to the core.
                fetch_en = !fetch_done_q;
                if (imem.imem_we && last_wr_q) state_d = S_RUN;
            end
            S_RUN: begin
                uart_rdreq      = core_uart_rdreq;
                core_uart_empty = uart_empty;
                core_run        = 1'b1;
            end
            S_ERR: begin
                boot_err = 1'b1;
            end
            default: state_d = S_LEN;
        endcase
        if (fetch_en) uart_rdreq = !uart_empty && !rd_pending_q;
        if (rst)      uart_rdreq = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pending_q    <= 1'b0;
            fetch_done_q    <= 1'b0;
            last_wr_q       <= 1'b0;
            idx_q           <= '0;
            len_q           <= '0;
            imem.imem_we    <= 1'b0;
            imem.imem_addr  <= '0;
            imem.imem_wdata <= '0;
        end else begin
            rd_pending_q <= uart_rdreq && fetch_en;
            imem.imem_we <= 1'b0;
            if (state_q == S_LEN && word_done) begin
                len_q        <= word[ADDR_W:0];
                idx_q        <= '0;
                fetch_done_q <= 1'b0;
                last_wr_q    <= 1'b0;
            end
            if (state_q == S_DATA && word_done) begin
                imem.imem_we    <= 1'b1;
                imem.imem_addr  <= ADDR_W'(BASE) + idx_q[ADDR_W-1:0];
                imem.imem_wdata <= word;
                idx_q           <= idx_q + IDX_ONE;
                if (idx_q + IDX_ONE == len_q) begin
                    fetch_done_q <= 1'b1;
                    last_wr_q    <= 1'b1;
                end
            end
        end
    end

    assign dbg_state = state_q;
endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader: FIFO model, write scoreboard, timing checks.
module tb_uart_boot_loader;
    import boot_pkg::*;

    localparam int ADDR_W    = 14;
    localparam int MAX_WORDS = 16;
    localparam int AW        = ADDR_W + 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic uart_empty = 1'b1;
    logic [7:0] uart_in = 8'd0;
    logic core_uart_rdreq = 1'b0;
    logic uart_rdreq, core_uart_empty, core_run, boot_err;
    boot_state_e dbg_state;

    uart_boot_loader_if #(.ADDR_W(ADDR_W)) imem ();

    uart_boot_loader #(.ADDR_W(ADDR_W), .BASE(0), .MAX_WORDS(MAX_WORDS)) dut (
        .clk             (clk),
        .rst             (rst),
        .uart_empty      (uart_empty),
        .uart_in         (uart_in),
        .uart_rdreq      (uart_rdreq),
        .core_uart_rdreq (core_uart_rdreq),
        .core_uart_empty (core_uart_empty),
        .imem            (imem),
        .core_run        (core_run),
        .boot_err        (boot_err),
        .dbg_state       (dbg_state)
    );

    always #5 clk = ~clk;

    logic [7:0]    fifo_q[$];
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] exp_w;
    logic force_empty = 1'b0;
    int n_cmp = 0, n_bad = 0, cyc = 0, wr_cnt = 0;
    int last_we_cyc = -10, run_rise_cyc = -1, err_rise_cyc = -1, last_rd_cyc = -1;
    int rd_empty_cnt = 0, we_back2back = 0, w0 = 0;
    logic prev_we = 1'b0, prev_run = 1'b0, prev_err = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // RX FIFO model: a request at a posedge presents the next byte for the following cycle.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (uart_rdreq) begin
            last_rd_cyc <= cyc;
            if (uart_empty && !core_run) rd_empty_cnt <= rd_empty_cnt + 1;
            if (fifo_q.size() > 0) uart_in <= fifo_q.pop_front();
        end
    end

    always @(negedge clk) begin
        #1 uart_empty = force_empty || (fifo_q.size() == 0);
    end

    // Monitor: every write pops the expected queue.
    always @(negedge clk) begin
        if (imem.imem_we) begin
            wr_cnt++;
            last_we_cyc = cyc;
            if (prev_we) we_back2back++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, none expected",
                         imem.imem_addr, imem.imem_wdata);
            end else begin
                exp_w = exp_q.pop_front();
                check("imem_write", {imem.imem_addr, imem.imem_wdata}, exp_w);
            end
        end
        if (core_run && !prev_run) run_rise_cyc = cyc;
        if (boot_err && !prev_err) err_rise_cyc = cyc;
        prev_we  = imem.imem_we;
        prev_run = core_run;
        prev_err = boot_err;
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        fifo_q.delete();
        core_uart_rdreq = 1'b0;
        force_empty = 1'b0;
        cycles(3);
        rst = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) fifo_q.push_back(w[i*8 +: 8]);
    endtask

    task automatic push_word_gapped(input logic [31:0] w);
        int k;
        for (int i = 0; i < 4; i++) begin
            fifo_q.push_back(w[i*8 +: 8]);
            k = 0;
            while (fifo_q.size() != 0 && k < 20) begin
                cycles(1);
                k++;
            end
            if (fifo_q.size() != 0) check("gap_byte_taken_timeout", 64'(fifo_q.size()), 64'd0);
            cycles(5);
        end
    endtask

    task automatic wait_done(input string name, input int budget);
        int k = 0;
        while (!(core_run || boot_err) && k < budget) begin
            cycles(1);
            k++;
        end
        if (!(core_run || boot_err)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: no core_run/boot_err after %0d cycles", name, budget);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic a, b;

        // Reset values, with bytes already waiting in the FIFO.
        cycles(3);
        push_word(32'd2);
        cycles(2);
        check("rst_uart_rdreq", uart_rdreq, 0);
        check("rst_imem_we", imem.imem_we, 0);
        check("rst_imem_addr", imem.imem_addr, 0);
        check("rst_imem_wdata", imem.imem_wdata, 0);
        check("rst_core_run", core_run, 0);
        check("rst_boot_err", boot_err, 0);
        check("rst_core_uart_empty", core_uart_empty, 1);
        check("rst_fifo_untouched", 64'(fifo_q.size()), 64'd4);
        check("rst_state", dbg_state, S_LEN);

        // N=2 image, FIFO never empty.
        exp_q.push_back({14'd0, 32'h0000_0013});
        exp_q.push_back({14'd1, 32'hDEAD_BEEF});
        push_word(32'h0000_0013);
        push_word(32'hDEAD_BEEF);
        w0 = wr_cnt;
        rst = 1'b0;
        cycles(1);
        check("boot_core_empty_forced", core_uart_empty, 1);
        wait_done("img2_done", 200);
        check("img2_core_run", core_run, 1);
        check("img2_run_latency", 64'(run_rise_cyc), 64'(last_we_cyc + 1));
        check("img2_write_count", 64'(wr_cnt - w0), 64'd2);
        check("img2_exp_drained", 64'(exp_q.size()), 64'd0);

        // Same image with 5 empty cycles between bytes; core requests must be ignored.
        do_reset();
        exp_q.push_back({14'd0, 32'h0000_0013});
        exp_q.push_back({14'd1, 32'hDEAD_BEEF});
        w0 = wr_cnt;
        core_uart_rdreq = 1'b1;
        push_word_gapped(32'd2);
        push_word_gapped(32'h0000_0013);
        push_word_gapped(32'hDEAD_BEEF);
        wait_done("gap_done", 100);
        core_uart_rdreq = 1'b0;
        check("gap_core_run", core_run, 1);
        check("gap_run_latency", 64'(run_rise_cyc), 64'(last_we_cyc + 1));
        check("gap_write_count", 64'(wr_cnt - w0), 64'd2);
        check("gap_exp_drained", 64'(exp_q.size()), 64'd0);

        // N=0: straight to run.
        do_reset();
        w0 = wr_cnt;
        push_word(32'd0);
        wait_done("n0_done", 50);
        check("n0_core_run", core_run, 1);
        check("n0_run_latency", 64'(run_rise_cyc), 64'(last_rd_cyc + 2));
        cycles(3);
        check("n0_write_count", 64'(wr_cnt - w0), 64'd0);

        // Length 17 > MAX_WORDS=16: halt, no further reads.
        do_reset();
        w0 = wr_cnt;
        push_word(32'h0000_0011);
        push_word(32'h1234_5678);
        wait_done("err_done", 50);
        check("err_boot_err", boot_err, 1);
        check("err_latency", 64'(err_rise_cyc), 64'(last_rd_cyc + 2));
        check("err_core_run", core_run, 0);
        cycles(20);
        check("err_core_run_hold", core_run, 0);
        check("err_sticky", boot_err, 1);
        check("err_no_reads", 64'(fifo_q.size()), 64'd4);
        check("err_state", dbg_state, S_ERR);
        check("err_write_count", 64'(wr_cnt - w0), 64'd0);

        // Reset mid-word, then N=1 image 0xCAFEBABE.
        do_reset();
        push_word(32'd1);
        fifo_q.push_back(8'hAA);
        fifo_q.push_back(8'hBB);
        k = 0;
        while (fifo_q.size() != 0 && k < 40) begin
            cycles(1);
            k++;
        end
        cycles(3);
        check("midword_state", dbg_state, S_DATA);
        do_reset();
        exp_q.push_back({14'd0, 32'hCAFE_BABE});
        w0 = wr_cnt;
        push_word(32'd1);
        push_word(32'hCAFE_BABE);
        wait_done("rst_img_done", 100);
        check("rst_img_core_run", core_run, 1);
        check("rst_img_write_count", 64'(wr_cnt - w0), 64'd1);
        check("rst_img_exp_drained", 64'(exp_q.size()), 64'd0);

        // Pass-through in RUN.
        for (int i = 0; i < 4; i++) push_word(32'h5A5A_5A5A);
        for (int i = 0; i < 4; i++) begin
            a = i[0];
            b = i[1];
            core_uart_rdreq = a;
            force_empty = b;
            cycles(1);
            check("run_rdreq_follow", uart_rdreq, a);
            check("run_empty_follow", core_uart_empty, b);
        end
        core_uart_rdreq = 1'b0;
        force_empty = 1'b0;
        cycles(2);

        check("no_rdreq_while_empty", 64'(rd_empty_cnt), 64'd0);
        check("no_back_to_back_we", 64'(we_back2back), 64'd0);
        check("exp_queue_final", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
